// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core data-bus bundle between the MIPS core and dmem_responder
interface dmem_responder_if;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        irq;

   modport master (output we, addr, wd, input rd, irq);
   modport slave  (input we, addr, wd, output rd, irq);
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM plus MMIO timer on the core data bus
// Timer block present only when DMEM_RESPONDER_TIMER_EN is defined.
module dmem_responder #(
   parameter int RAM_WORDS = 256
) (
   input  logic              clock,
   input  logic              reset,
   dmem_responder_if.slave   bus
);
   localparam int AW = $clog2(RAM_WORDS);

   logic [31:0]   ram_q [RAM_WORDS];
   logic [AW-1:0] ram_idx;
   logic [31:0]   rd_mmio;
   logic          unused_addr;

   assign ram_idx     = bus.addr[2 +: AW];
   assign unused_addr = &{1'b0, bus.addr};

   always_ff @(posedge clock) begin
      if (!reset && bus.we && !bus.addr[11]) begin
         ram_q[ram_idx] <= bus.wd;
      end
   end

   assign bus.rd = bus.addr[11] ? rd_mmio : ram_q[ram_idx];

`ifdef DMEM_RESPONDER_TIMER_EN
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        match_q, match_d;
   logic        irq_q, irq_d;
   logic        mmio_sel, hit;
   logic        wr_ctrl, wr_count, wr_compare, wr_status;

   // Only offsets 0x800..0x80C respond; the rest of the MMIO half reads 0.
   assign mmio_sel   = bus.addr[11] && (bus.addr[10:4] == 7'd0);
   assign wr_ctrl    = bus.we && mmio_sel && (bus.addr[3:2] == 2'd0);
   assign wr_count   = bus.we && mmio_sel && (bus.addr[3:2] == 2'd1);
   assign wr_compare = bus.we && mmio_sel && (bus.addr[3:2] == 2'd2);
   assign wr_status  = bus.we && mmio_sel && (bus.addr[3:2] == 2'd3);
   assign hit        = ctrl_q[0] && (count_q == compare_q);

   always_comb begin
      ctrl_d    = wr_ctrl ? bus.wd[2:0] : ctrl_q;
      compare_d = wr_compare ? bus.wd : compare_q;
      count_d   = count_q;
      if (wr_count) begin
         count_d = bus.wd;
      end else if (hit && ctrl_q[1]) begin
         count_d = 32'd0;
      end else if (ctrl_q[0]) begin
         count_d = count_q + 32'd1;
      end
      // A match in the same cycle as a W1C clear keeps the flag set.
      match_d = hit | (match_q & ~(wr_status & bus.wd[0]));
      irq_d   = match_d & ctrl_d[2];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl_q    <= 3'd0;
         count_q   <= 32'd0;
         compare_q <= 32'hFFFF_FFFF;
         match_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         match_q   <= match_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      rd_mmio = 32'd0;
      if (mmio_sel) begin
         case (bus.addr[3:2])
            2'd0:    rd_mmio = {29'd0, ctrl_q};
            2'd1:    rd_mmio = count_q;
            2'd2:    rd_mmio = compare_q;
            default: rd_mmio = {31'd0, match_q};
         endcase
      end
   end

   assign bus.irq = irq_q;
`else
   assign rd_mmio = 32'd0;
   assign bus.irq = 1'b0;
`endif
endmodule
